fetch_queue_stage: RTL and testbench



---
 rtl/fetch_queue_stage_if.sv | 10 +
 rtl/fetch_queue_stage.sv | 94 +++++++++
 tb/tb_fetch_queue_stage.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_stage_if.sv
// fetch_queue_stage_if: instruction memory request/response port, fetch stage is master.
interface fetch_queue_stage_if #(parameter int XLEN = 32);
  logic            mem_start;
  logic            mem_ready;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_data;
  logic            mem_data_valid;
  modport master(output mem_start, mem_addr, input mem_ready, mem_data, mem_data_valid);
  modport slave(input mem_start, mem_addr, output mem_ready, mem_data, mem_data_valid);
endinterface

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: instruction fetch with QDEPTH-entry prefetch queue feeding the ID register.
// Optional FETCH_PERF_EN adds saturating stall/flush/discard counters.
module fetch_queue_stage #(
  parameter int              XLEN     = 32,
  parameter int              QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP_PC   = '1,
  parameter logic [XLEN-1:0] NOP_INST = 'h13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fetch_queue_stage_if.master      mem,
  input  logic [XLEN-1:0]          wb_reg_pc,
  input  logic                     wb_branch_hazard,
  input  logic                     stall_flg,
  output logic [XLEN-1:0]          id_reg_pc,
  output logic [XLEN-1:0]          id_inst,
  output logic [$clog2(QDEPTH):0]  q_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]              perf_stall_cycles,
  output logic [31:0]              perf_flushes,
  output logic [31:0]              perf_discards
`endif
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {WAIT_READY, WAIT_VALID} state_t;
  state_t state, state_next;
  logic [XLEN-1:0] fetch_pc, req_pc, addr;
  logic [XLEN-1:0] q_pc [QDEPTH];
  logic [XLEN-1:0] q_inst [QDEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_next;
  logic discard, resp, drop, bypass, push, pop, issue;
  always_comb begin
    resp = state == WAIT_VALID && mem.mem_data_valid;
    drop = resp && (discard || wb_branch_hazard);
    bypass = resp && !drop && !stall_flg && q_count == '0;
    push = resp && !drop && !bypass;
    pop = !stall_flg && !wb_branch_hazard && q_count != '0;
    count_next = wb_branch_hazard ? '0 : q_count + CW'(push) - CW'(pop);
    addr = wb_branch_hazard ? wb_reg_pc : fetch_pc;
    // a slot is reserved at issue time, so a response can never find the queue full
    issue = mem.mem_ready && (wb_branch_hazard ? state == WAIT_READY
                                               : (state == WAIT_READY || resp) && count_next < CW'(QDEPTH));
    state_next = issue ? WAIT_VALID : resp ? WAIT_READY : state;
    mem.mem_start = issue;
    mem.mem_addr = issue ? addr : NOP_PC;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= WAIT_READY;
    else state <= state_next;
  always_ff @(posedge clk)
    if (push) begin
      q_pc[wr_ptr] <= req_pc;
      q_inst[wr_ptr] <= mem.mem_data;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      req_pc <= RESET_PC;
      discard <= 1'b0;
      q_count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      id_reg_pc <= NOP_PC;
      id_inst <= NOP_INST;
    end else begin
      fetch_pc <= issue ? addr + XLEN'(4) : wb_branch_hazard ? wb_reg_pc : fetch_pc;
      if (issue) req_pc <= addr;
      discard <= wb_branch_hazard ? state == WAIT_VALID && !mem.mem_data_valid
                                  : resp ? 1'b0 : discard;
      q_count <= count_next;
      rd_ptr <= wb_branch_hazard ? '0 : rd_ptr + AW'(pop);
      wr_ptr <= wb_branch_hazard ? '0 : wr_ptr + AW'(push);
      if (!stall_flg) begin
        id_reg_pc <= wb_branch_hazard ? NOP_PC : pop ? q_pc[rd_ptr] : bypass ? req_pc : NOP_PC;
        id_inst <= wb_branch_hazard ? NOP_INST : pop ? q_inst[rd_ptr] : bypass ? mem.mem_data : NOP_INST;
      end
    end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_flushes <= '0;
      perf_discards <= '0;
    end else begin
      if (stall_flg && q_count == CW'(QDEPTH) && perf_stall_cycles != '1) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (wb_branch_hazard && perf_flushes != '1) perf_flushes <= perf_flushes + 32'd1;
      if (drop && perf_discards != '1) perf_discards <= perf_discards + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb_fetch_queue_stage: table-driven cycle vectors plus hand sequences for flush, reset and wrap.
module tb_fetch_queue_stage;
  localparam logic [31:0] NOP = 32'hFFFFFFFF;
  localparam logic [31:0] NOPI = 32'h00000013;
  logic clk = 1'b0;
  logic rst_n, stall, hz, ready, auto, man_valid, auto_valid, found;
  logic [31:0] wb, man_data, auto_data, id_reg_pc, id_inst;
  logic [2:0] q_count;
  int checks = 0, errors = 0;
  typedef struct {
    logic stall;
    logic hz;
    logic [31:0] wb;
    logic [31:0] pc;
    logic [31:0] q;
    logic st;
    logic [31:0] addr;
  } vec_t;
  vec_t tbl[25];
  fetch_queue_stage_if #(.XLEN(32)) mif();
  fetch_queue_stage dut (
    .clk(clk), .rst_n(rst_n), .mem(mif), .wb_reg_pc(wb), .wb_branch_hazard(hz),
    .stall_flg(stall), .id_reg_pc(id_reg_pc), .id_inst(id_inst), .q_count(q_count)
  );
  always #5 clk = ~clk;
  // memory model: one-cycle latency, data is the inverted address
  always @(posedge clk) begin
    auto_valid <= mif.mem_start;
    auto_data <= ~mif.mem_addr;
  end
  assign mif.mem_ready = ready;
  assign mif.mem_data_valid = auto ? auto_valid : man_valid;
  assign mif.mem_data = auto ? auto_data : man_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ready = 1'b0; stall = 1'b0; hz = 1'b0; man_valid = 1'b0; wb = '0;
    @(negedge clk);
    #1;
    chk("rst_pc", id_reg_pc, NOP);
    chk("rst_inst", id_inst, NOPI);
    chk("rst_q", 32'(q_count), 32'd0);
    chk("rst_start", 32'(mif.mem_start), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic vec_t v(logic s, logic h, logic [31:0] w, logic [31:0] pc, logic [31:0] q, logic st, logic [31:0] a);
    v = '{s, h, w, pc, q, st, a};
  endfunction

  initial begin
    rst_n = 1'b1; stall = 1'b0; hz = 1'b0; ready = 1'b0; auto = 1'b1;
    man_valid = 1'b0; man_data = '0; wb = '0;
    tbl[0]  = v(1'b0, 1'b0, 0, NOP, 0, 1'b1, 32'd0);
    tbl[1]  = v(1'b0, 1'b0, 0, NOP, 0, 1'b1, 32'd4);
    tbl[2]  = v(1'b0, 1'b0, 0, 32'd0, 0, 1'b1, 32'd8);
    tbl[3]  = v(1'b0, 1'b0, 0, 32'd4, 0, 1'b1, 32'd12);
    tbl[4]  = v(1'b0, 1'b0, 0, 32'd8, 0, 1'b1, 32'd16);
    tbl[5]  = v(1'b1, 1'b0, 0, 32'd12, 0, 1'b1, 32'd20);
    tbl[6]  = v(1'b1, 1'b0, 0, 32'd12, 1, 1'b1, 32'd24);
    tbl[7]  = v(1'b1, 1'b0, 0, 32'd12, 2, 1'b1, 32'd28);
    tbl[8]  = v(1'b1, 1'b0, 0, 32'd12, 3, 1'b0, NOP);
    for (int i = 9; i < 15; i++) tbl[i] = v(1'b1, 1'b0, 0, 32'd12, 4, 1'b0, NOP);
    tbl[15] = v(1'b0, 1'b0, 0, 32'd12, 4, 1'b1, 32'd32);
    for (int i = 16; i < 21; i++) tbl[i] = v(1'b0, 1'b0, 0, 32'(4 * i - 48), 3, 1'b1, 32'(4 * i - 28));
    tbl[21] = v(1'b1, 1'b1, 32'h200, 32'd36, 3, 1'b0, NOP);
    tbl[22] = v(1'b0, 1'b0, 0, 32'd36, 0, 1'b1, 32'h200);
    tbl[23] = v(1'b0, 1'b0, 0, NOP, 0, 1'b1, 32'h204);
    tbl[24] = v(1'b0, 1'b0, 0, 32'h200, 0, 1'b1, 32'h208);

    do_reset();
    auto = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      ready = 1'b1; stall = tbl[i].stall; hz = tbl[i].hz; wb = tbl[i].wb;
      #1;
      chk($sformatf("row%0d_pc", i), id_reg_pc, tbl[i].pc);
      chk($sformatf("row%0d_inst", i), id_inst, tbl[i].pc == NOP ? NOPI : ~tbl[i].pc);
      chk($sformatf("row%0d_q", i), 32'(q_count), tbl[i].q);
      chk($sformatf("row%0d_start", i), 32'(mif.mem_start), 32'(tbl[i].st));
      chk($sformatf("row%0d_addr", i), mif.mem_addr, tbl[i].addr);
    end

    // hazard while a request is outstanding: in-flight response must be dropped
    do_reset();
    auto = 1'b0;
    @(negedge clk);
    ready = 1'b1; hz = 1'b1; wb = 32'h10;
    #1;
    chk("hzwr_start", 32'(mif.mem_start), 32'd1);
    chk("hzwr_addr", mif.mem_addr, 32'h10);
    @(negedge clk);
    wb = 32'h100;
    #1;
    chk("hzwv_start", 32'(mif.mem_start), 32'd0);
    @(negedge clk);
    hz = 1'b0; man_valid = 1'b1; man_data = 32'hDEADBEEF;
    #1;
    chk("hz_q", 32'(q_count), 32'd0);
    chk("hz_bubble", id_reg_pc, NOP);
    @(negedge clk);
    man_valid = 1'b0; auto = 1'b1;
    #1;
    chk("hz_drop_pc", id_reg_pc, NOP);
    chk("hz_drop_inst", id_inst, NOPI);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      #1;
      if (id_reg_pc !== NOP) found = 1'b1;
    end
    chk("hz_timeout", 32'(found), 32'd1);
    chk("hz_target_pc", id_reg_pc, 32'h100);
    chk("hz_target_inst", id_inst, ~32'h100);

    // reset while waiting for a response, then a late valid pulse
    do_reset();
    auto = 1'b0;
    @(negedge clk);
    ready = 1'b1;
    #1;
    chk("rv_start", 32'(mif.mem_start), 32'd1);
    chk("rv_addr", mif.mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b0; ready = 1'b0;
    #1;
    chk("rv_rst_pc", id_reg_pc, NOP);
    chk("rv_rst_start", 32'(mif.mem_start), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; man_valid = 1'b1; man_data = 32'h12345678;
    #1;
    chk("rv_late_q", 32'(q_count), 32'd0);
    @(negedge clk);
    man_valid = 1'b0;
    #1;
    chk("rv_late_pc", id_reg_pc, NOP);
    chk("rv_late_inst", id_inst, NOPI);
    chk("rv_late_q2", 32'(q_count), 32'd0);
    @(negedge clk);
    ready = 1'b1;
    #1;
    chk("rv_refetch_start", 32'(mif.mem_start), 32'd1);
    chk("rv_refetch_addr", mif.mem_addr, 32'd0);

    // address wrap at the top of the address space
    do_reset();
    auto = 1'b1;
    @(negedge clk);
    ready = 1'b1; hz = 1'b1; wb = 32'hFFFFFFFC;
    #1;
    chk("wrap_addr0", mif.mem_addr, 32'hFFFFFFFC);
    @(negedge clk);
    hz = 1'b0;
    #1;
    chk("wrap_start", 32'(mif.mem_start), 32'd1);
    chk("wrap_addr1", mif.mem_addr, 32'd0);
    @(negedge clk);
    #1;
    chk("wrap_pc", id_reg_pc, 32'hFFFFFFFC);
    chk("wrap_inst", id_inst, 32'h00000003);
    chk("wrap_addr2", mif.mem_addr, 32'd4);
    @(negedge clk);
    #1;
    chk("wrap_pc_next", id_reg_pc, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
